// File: rtl/sum_tree_pkg.sv
// Shared constants and helpers for the sum_tree_ext datapath: width maths
// and the saturate/wrap output fitting used on the total and extrinsic lanes.
package sum_tree_pkg;

    localparam logic MODE_SIGNED    = 1'b0;
    localparam logic MODE_MAGNITUDE = 1'b1;

    // Working width for fit(); the accumulator width must stay below this.
    localparam int FIT_W = 64;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of tree nodes present after l pairwise-add levels.
    function automatic int level_count(input int n, input int l);
        int c;
        c = n;
        for (int k = 0; k < l; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    function automatic logic signed [FIT_W-1:0] fit(
        input  logic signed [FIT_W-1:0] v,
        input  int                      out_w,
        input  bit                      saturate,
        output logic                    changed
    );
        logic signed [FIT_W-1:0] hi;
        logic signed [FIT_W-1:0] lo;
        logic signed [FIT_W-1:0] wrapped;
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        wrapped = (v <<< (FIT_W - out_w)) >>> (FIT_W - out_w);
        changed = (v > hi) || (v < lo);
        if (!saturate) begin
            return wrapped;
        end
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sum_tree_ext_level.sv
// One registered level of the adder tree: nodes 2k and 2k+1 are summed,
// an odd trailing node passes through unchanged.
module sum_tree_level #(
    parameter int IN_COUNT  = 2,
    parameter int ACC_WIDTH = 10
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    en,
    input  logic [IN_COUNT*ACC_WIDTH-1:0]           in_data,
    output logic [((IN_COUNT+1)/2)*ACC_WIDTH-1:0]   out_data
);

    localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

    logic [OUT_COUNT*ACC_WIDTH-1:0] node_d;
    logic [OUT_COUNT*ACC_WIDTH-1:0] node_q;

    for (genvar k = 0; k < OUT_COUNT; k++) begin : g_node
        if (2 * k + 1 < IN_COUNT) begin : g_pair
            assign node_d[k*ACC_WIDTH +: ACC_WIDTH] =
                in_data[(2*k)*ACC_WIDTH +: ACC_WIDTH] + in_data[(2*k+1)*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_pass
            assign node_d[k*ACC_WIDTH +: ACC_WIDTH] = in_data[(2*k)*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            node_q <= '0;
        end else if (en) begin
            node_q <= node_d;
        end
    end

    assign out_data = node_q;

endmodule

// File: rtl/sum_tree_ext.sv
// Pipelined masked sum tree with per-lane leave-one-out outputs. Data, valid
// and tag move together as a stall-able train; a stall freezes every stage.
module sum_tree_ext
    import sum_tree_pkg::*;
#(
    parameter int TAG_WIDTH   = 32,
    parameter int BLOCKLENGTH = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_WIDTH   = 8,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  logic [TAG_WIDTH-1:0]            tag_in,
    input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in,
    input  logic [BLOCKLENGTH-1:0]          mask_in,
    input  logic                            mode_in,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [TAG_WIDTH-1:0]            tag_out,
    output logic [OUT_WIDTH-1:0]            sum,
    output logic [OUT_WIDTH*BLOCKLENGTH-1:0] ext_out,
    output logic                            overflow,
    output logic                            busy
);

    localparam int N      = BLOCKLENGTH;
    localparam int LEVELS = clog2(N);
    localparam int ACC    = DATA_WIDTH + LEVELS + 1;
    localparam int STAGES = LEVELS + 2;

    logic                 advance;
    logic [STAGES-1:0]    vld_d, vld_q;
    logic [TAG_WIDTH-1:0] tag_d [STAGES];
    logic [TAG_WIDTH-1:0] tag_q [STAGES];
    logic [N*ACC-1:0]     x_d [LEVELS+1];
    logic [N*ACC-1:0]     x_q [LEVELS+1];
    logic [ACC-1:0]       total;
    logic [OUT_WIDTH-1:0]   sum_d, sum_q;
    logic [OUT_WIDTH*N-1:0] ext_d, ext_q;
    logic                   ovf_d, ovf_q;

    assign advance   = !vld_q[STAGES-1] || ready_in;
    assign ready_out = advance;

    // x_q[0] is the input register; x_q[1..LEVELS] keep lane values aligned with the tree.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = level_count(N, l);
        logic [CNT*ACC-1:0] bus;
        if (l == 0) begin : g_root
            assign bus = x_q[0];
        end else begin : g_add
            sum_tree_level #(
                .IN_COUNT  (level_count(N, l - 1)),
                .ACC_WIDTH (ACC)
            ) u_level (
                .clk      (clk),
                .reset    (reset),
                .en       (advance),
                .in_data  (g_lvl[l-1].bus),
                .out_data (bus)
            );
        end
    end

    assign total = g_lvl[LEVELS].bus;

    always_comb begin
        logic signed [ACC-1:0]   lane;
        logic signed [FIT_W-1:0] total_w;
        logic signed [FIT_W-1:0] diff_w;
        logic signed [FIT_W-1:0] fitted;
        logic                    changed;

        vld_d = {vld_q[STAGES-2:0], valid_in};
        tag_d[0] = tag_in;
        for (int s = 1; s < STAGES; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        x_d[0] = '0;
        for (int i = 0; i < N; i++) begin
            lane = ACC'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
            if (mode_in == MODE_MAGNITUDE && lane[ACC-1]) begin
                lane = -lane;
            end
            x_d[0][i*ACC +: ACC] = mask_in[i] ? lane : '0;
        end
        for (int k = 1; k <= LEVELS; k++) begin
            x_d[k] = x_q[k-1];
        end

        total_w = FIT_W'($signed(total));
        fitted  = fit(total_w, OUT_WIDTH, SATURATE, changed);
        sum_d   = fitted[OUT_WIDTH-1:0];
        ovf_d   = changed;
        ext_d   = '0;
        for (int i = 0; i < N; i++) begin
            diff_w = total_w - FIT_W'($signed(x_q[LEVELS][i*ACC +: ACC]));
            fitted = fit(diff_w, OUT_WIDTH, SATURATE, changed);
            ext_d[i*OUT_WIDTH +: OUT_WIDTH] = fitted[OUT_WIDTH-1:0];
            ovf_d = ovf_d | changed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_q[s] <= '0;
            end
            for (int k = 0; k <= LEVELS; k++) begin
                x_q[k] <= '0;
            end
            sum_q <= '0;
            ext_q <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_d;
            for (int s = 0; s < STAGES - 1; s++) begin
                tag_q[s] <= tag_d[s];
            end
            for (int k = 0; k <= LEVELS; k++) begin
                x_q[k] <= x_d[k];
            end
            // Result registers only update for a real beat, so bubbles keep the last result visible.
            if (vld_q[STAGES-2]) begin
                tag_q[STAGES-1] <= tag_d[STAGES-1];
                sum_q <= sum_d;
                ext_q <= ext_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign valid_out = vld_q[STAGES-1];
    assign tag_out   = tag_q[STAGES-1];
    assign sum       = sum_q;
    assign ext_out   = ext_q;
    assign overflow  = ovf_q;
    assign busy      = |vld_q;

endmodule

// File: doc/sum_tree_ext.md
Name: sum_tree_ext

Overview:
- Parametrised, pipelined signed sum tree over BLOCKLENGTH lanes, with the following features:
  - per-lane mask;
  - selectable signed/magnitude mode;
  - internal width growth;
  - saturating or wrapping output;
  - per-lane extrinsic (leave-one-out) outputs.
- Sits in the ADMM-LP check/variable-node datapath, where both the total and the total-minus-self values are needed.
- Carries a tag alongside data under valid/ready flow control.

Parameters:
- TAG_WIDTH, 32, width of the sideband tag carried with each beat.
- BLOCKLENGTH, 4, number of input lanes N (N >= 1).
- DATA_WIDTH, 8, signed width of each input lane.
- OUT_WIDTH, 8, signed width of the sum and of each extrinsic output.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- valid_in  in  1  upstream beat valid.
- ready_out  out  1  block can accept a beat this cycle.
- tag_in  in  TAG_WIDTH  tag for the incoming beat.
- data_in  in  DATA_WIDTH*N  packed signed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- mask_in  in  N  1 = lane participates, 0 = lane treated as zero.
- mode_in  in  1  0 = signed sum, 1 = sum of magnitudes.
- valid_out  out  1  result valid.
- ready_in  in  1  downstream accepts the result.
- tag_out  out  TAG_WIDTH  tag of the current result.
- sum  out  OUT_WIDTH  total, saturated or wrapped.
- ext_out  out  OUT_WIDTH*N  lane i = total - x[i], saturated or wrapped.
- overflow  out  1  sum or any ext lane was clamped/wrapped.
- busy  out  1  any valid beat is inside the pipeline.

Behaviour:
- Constants:
  - LEVELS = ceil(log2 N), with LEVELS = 0 for N = 1.
  - ACC_WIDTH = DATA_WIDTH + LEVELS + 1. The extra bit covers the magnitude of -2^(DATA_WIDTH-1).
- Stage 0 (input register): x[i] = mask_in[i] ? (mode_in ? |d[i]| : d[i]) : 0, sign-extended to ACC_WIDTH.
- Stages 1..LEVELS (adder levels): adjacent pairs are added (lanes 2k and 2k+1). With an odd count, the last element passes through registered, unchanged. All arithmetic is at ACC_WIDTH, so nothing can overflow internally.
- x[] delay line: stage-0 x[] values are delayed LEVELS stages alongside the tree.
- Final stage: register sum = fit(total), ext[i] = fit(total - x[i]), and overflow.
- fit() behaviour:
  - SATURATE=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - SATURATE=0: keep the low OUT_WIDTH bits.
  - overflow = 1 iff fit changed any value.
- Latency is exactly LEVELS+2 cycles from accept to valid_out when unstalled. Throughput is 1 beat/cycle.
- Flow control:
  - advance = !valid_out || ready_in, and ready_out = advance. This is a combinational ready_in -> ready_out path, by design.
  - Accept occurs when valid_in && ready_out.
  - On !advance, every stage (data, valid bit, tag) holds. No beat is lost or duplicated.
  - Bubbles are not collapsed; the pipeline moves as a train.
- Valid and tag shift registers, LEVELS+2 deep, travel with the data. tag_out and valid_out come from the last stage.
- busy = OR of all stage valid bits.
- Reset (asynchronous, any time, including mid-operation): all stage valids, data, tags and outputs go to 0; ready_out = 1 on the first cycle after release. In-flight beats are discarded.
- Outputs while valid_out = 0 hold the last computed values. Verification must not check them.
- N = 1: latency 2, sum = fit(x[0]), ext_out = 0.

Decomposition:
- Package sum_tree_pkg contains:
  - clog2 constant function;
  - fit/saturate function parametrised by input/output width;
  - MODE_SIGNED = 0 and MODE_MAGNITUDE = 1 constants.
- Sub-module sum_tree_level: one registered pairwise-add level with parameters IN_COUNT and ACC_WIDTH, plus enable; output count ceil(IN_COUNT/2). The top generates LEVELS instances.
- Valid/tag/x delay logic stays in the top.

Test Plan:
1. N=5, DW=8, OW=8. Lanes 1,2,3,4,5, mask all 1, mode 0, ready_in=1 -> valid_out exactly 5 cycles after accept; sum=15; ext=14,13,12,11,10; overflow=0; tag echoed.
2. N=4, all lanes 127, SATURATE=1 -> sum=127, every ext=127, overflow=1. Same run with SATURATE=0 -> sum=508 mod 256 = -4, ext=381 wrapped = 125, overflow=1.
3. N=4, lanes -3,-1,0,5 -> mode 1 gives sum=9; mode 0 gives sum=1. Mask 0b1110 in mode 0 -> sum=4, ext[0]=4.
4. Streaming 8 beats back-to-back with ready_in held low for 3 cycles once valid_out rises -> ready_out low those 3 cycles, outputs stable; all 8 results arrive in order with the correct tags, no drops or duplicates; busy falls after the last result.
5. Reset asserted asynchronously with 3 beats in flight -> valid_out, busy, sum, ext_out, overflow and tag_out all 0 immediately. After release, a new beat returns correctly at nominal latency.
6. N=1, lane -128, mode 1, OW=8, SATURATE=1 -> sum=127, overflow=1, ext=0, latency 2.
